// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Generates the stall/flush controls for an in-order pipelined core:
//   - load-use hazard between ID and a load in EX (one bubble cycle)
//   - taken-branch redirect from EX (flush held for FLUSH_CYCLES cycles)
//   - data-memory wait states (full freeze until ready or timeout)
// Also keeps a saturating count of stall cycles and a sticky timeout flag.
//
// Ports
//   clk, reset         clock; synchronous active-low reset
//   id_*               ID-stage instruction: valid, sources, source usage
//   ex_*               EX-stage instruction: valid, load flag, rd, branch taken
//   mem_req/mem_ready  MEM-stage data access handshake
//   stall, flush       freeze / kill IF/ID
//   pc_write_en        PC update enable
//   ifid_write_en      IF/ID register write enable
//   idex_bubble        insert NOP into ID/EX
//   mem_timeout        sticky: a memory wait ran for MAX_MEM_WAIT cycles
//   stall_count        saturating number of cycles with stall=1
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_MEM_WAIT = 8,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              stall,
  output logic              flush,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              idex_bubble,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam int WCW = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [FCW-1:0]   FRELOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic [WCW-1:0]   WMAX    = WCW'(MAX_MEM_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOAD_USE = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             hz;

  assign hz = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    wcnt_d        = wcnt_q;
    mem_timeout_d = mem_timeout_q;
    stall         = 1'b0;
    flush         = 1'b0;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    idex_bubble   = 1'b0;

    unique case (state_q)
      ST_RUN, ST_LOAD_USE: begin
        if (ex_branch_taken) begin
          flush       = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FRELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else if (mem_req && !mem_ready) begin
          stall         = 1'b1;
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          state_d       = ST_MEM_WAIT;
          wcnt_d        = WCW'(1);
        end else if (hz && (state_q == ST_RUN)) begin
          // In LOAD_USE the load has already advanced to MEM and is forwarded,
          // so the same register match must not stall a second time.
          stall         = 1'b1;
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_bubble   = 1'b1;
          state_d       = ST_LOAD_USE;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_FLUSH: begin
        flush       = 1'b1;
        idex_bubble = 1'b1;
        if (ex_branch_taken) begin
          fcnt_d = FRELOAD;
        end else if (fcnt_q == FCW'(1)) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        // EX is frozen here, so branch and load-use are re-evaluated in RUN.
        if (mem_ready) begin
          state_d = ST_RUN;
        end else if (wcnt_q == WMAX) begin
          // Give up: release the pipeline and flag the timeout.
          mem_timeout_d = 1'b1;
          state_d       = ST_RUN;
        end else begin
          stall         = 1'b1;
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          wcnt_d        = wcnt_q + 1'b1;
        end
      end

      default: state_d = ST_RUN;
    endcase

    // Outputs are forced idle while reset is held, independent of state.
    if (!reset) begin
      stall         = 1'b0;
      flush         = 1'b0;
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_bubble   = 1'b0;
    end

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      fcnt_q        <= '0;
      wcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      wcnt_q        <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl (REG_AW=5, FLUSH_CYCLES=2,
// MAX_MEM_WAIT=8, CNT_W=16). Each cycle the inputs are driven on the falling
// edge, the expected outputs are pushed to a scoreboard queue, and 1 ns later
// the entry is popped and compared against the DUT.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_valid, ex_mem_read, ex_branch_taken;
  logic        mem_req, mem_ready;
  logic        stall, flush, pc_write_en, ifid_write_en, idex_bubble, mem_timeout;
  logic [15:0] stall_count;

  typedef struct {
    string       tag;
    logic        s, f, pc, ifid, bub, tmo;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_AW(5), .FLUSH_CYCLES(2), .MAX_MEM_WAIT(8), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall(stall), .flush(flush), .pc_write_en(pc_write_en),
    .ifid_write_en(ifid_write_en), .idex_bubble(idex_bubble),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, expv);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rd = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  // Load in EX writing rd, ID reading rs1 (u1) / rs2 (u2).
  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    id_valid = 1; ex_valid = 1; ex_mem_read = 1; ex_rd = rd;
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
  endtask

  // One cycle: push expectation, compare after settling, advance to next negedge.
  task automatic step(input string tag, input logic s, input logic f, input logic pc,
                      input logic ifid, input logic bub, input logic tmo);
    exp_t e, g;
    e.tag = tag; e.s = s; e.f = f; e.pc = pc; e.ifid = ifid; e.bub = bub;
    e.tmo = tmo; e.cnt = exp_cnt;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk(g.tag, "stall",       32'(stall),         32'(g.s));
    chk(g.tag, "flush",       32'(flush),         32'(g.f));
    chk(g.tag, "pc_write_en", 32'(pc_write_en),   32'(g.pc));
    chk(g.tag, "ifid_wen",    32'(ifid_write_en), 32'(g.ifid));
    chk(g.tag, "idex_bubble", 32'(idex_bubble),   32'(g.bub));
    chk(g.tag, "mem_timeout", 32'(mem_timeout),   32'(g.tmo));
    chk(g.tag, "stall_count", 32'(stall_count),   32'(g.cnt));
    if (!reset) exp_cnt = 16'd0;
    else if (s) exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    @(negedge clk);

    // Reset held: every control low.
    step("rst0", 0,0,0,0,0,0);
    step("rst1", 0,0,0,0,0,0);
    step("rst2", 0,0,0,0,0,0);
    reset = 1'b1;
    step("rel0", 0,0,1,1,0,0);
    step("rel1", 0,0,1,1,0,0);

    // Load-use on rs1: one bubble, then masked in LOAD_USE.
    load_use(5'd5, 5'd5, 1, 5'd0, 0);
    step("lu_rs1_a", 1,0,0,0,1,0);
    step("lu_rs1_b", 0,0,1,1,0,0);
    idle();
    step("lu_idle", 0,0,1,1,0,0);
    // Destination x0 never hazards.
    load_use(5'd0, 5'd0, 1, 5'd0, 0);
    step("lu_x0_a", 0,0,1,1,0,0);
    step("lu_x0_b", 0,0,1,1,0,0);
    // Load-use on rs2.
    load_use(5'd7, 5'd1, 0, 5'd7, 1);
    step("lu_rs2", 1,0,0,0,1,0);
    idle();
    step("lu_rs2_idle", 0,0,1,1,0,0);
    // EX not valid: no hazard.
    load_use(5'd9, 5'd9, 1, 5'd0, 0);
    ex_valid = 0;
    step("lu_exinv", 0,0,1,1,0,0);

    // Single taken branch: flush for exactly two cycles.
    idle(); ex_branch_taken = 1;
    step("br_a", 0,1,1,1,1,0);
    idle();
    step("br_b", 0,1,1,1,1,0);
    step("br_done", 0,0,1,1,0,0);

    // Branch beats load-use in the same cycle.
    load_use(5'd5, 5'd5, 1, 5'd0, 0); ex_branch_taken = 1;
    step("brhz_a", 0,1,1,1,1,0);
    ex_branch_taken = 0;
    step("brhz_b", 0,1,1,1,1,0);
    step("brhz_lu", 1,0,0,0,1,0);
    idle();
    step("brhz_done", 0,0,1,1,0,0);

    // Back-to-back branches reload the flush counter.
    ex_branch_taken = 1;
    step("rl_a", 0,1,1,1,1,0);
    step("rl_b", 0,1,1,1,1,0);
    idle();
    step("rl_c", 0,1,1,1,1,0);
    step("rl_done", 0,0,1,1,0,0);

    // Branch arriving while in LOAD_USE is honoured.
    load_use(5'd3, 5'd3, 1, 5'd0, 0);
    step("lubr_lu", 1,0,0,0,1,0);
    ex_branch_taken = 1;
    step("lubr_a", 0,1,1,1,1,0);
    idle();
    step("lubr_b", 0,1,1,1,1,0);
    step("lubr_done", 0,0,1,1,0,0);

    // Memory wait: 4 frozen cycles, hz ignored meanwhile, release on ready.
    idle(); mem_req = 1;
    step("mw1", 1,0,0,0,0,0);
    load_use(5'd5, 5'd5, 1, 5'd0, 0);
    step("mw2", 1,0,0,0,0,0);
    step("mw3", 1,0,0,0,0,0);
    step("mw4", 1,0,0,0,0,0);
    idle(); mem_req = 1; mem_ready = 1;
    step("mw_rdy", 0,0,1,1,0,0);
    idle();
    step("mw_idle", 0,0,1,1,0,0);

    // Memory timeout: 8 frozen cycles, branch ignored, then release + sticky flag.
    mem_req = 1;
    for (int i = 0; i < 8; i++) begin
      ex_branch_taken = (i == 2);
      step($sformatf("to_%0d", i), 1,0,0,0,0,0);
    end
    ex_branch_taken = 0;
    step("to_exp", 0,0,1,1,0,0);
    idle();
    step("to_sticky0", 0,0,1,1,0,1);
    step("to_sticky1", 0,0,1,1,0,1);

    // Reset in the middle of a memory wait clears everything.
    mem_req = 1;
    step("rmw_a", 1,0,0,0,0,1);
    reset = 1'b0;
    step("rmw_rst", 0,0,0,0,0,1);
    reset = 1'b1; idle();
    step("rmw_after", 0,0,1,1,0,0);

    // Reset in the middle of a flush abandons it.
    ex_branch_taken = 1;
    step("rfl_a", 0,1,1,1,1,0);
    reset = 1'b0; idle();
    step("rfl_rst", 0,0,0,0,0,0);
    reset = 1'b1;
    step("rfl_after", 0,0,1,1,0,0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
